seq_mac_accumulator: RTL and testbench

//  Sequential multiply-accumulate stage for the matrix-multiplication datapath; computes one dot product per output.

---
 rtl/seq_mac_accumulator_pkg.sv | 15 +
 rtl/seq_mac_accumulator_ripple_carry_adder.sv | 31 +++
 rtl/seq_mac_accumulator.sv | 135 +++++++++++++
 tb/tb_seq_mac_accumulator.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mac_accumulator_pkg.sv
// Shared definitions for the sequential multiply-accumulate stage.
// Contents: default operand/accumulator widths and the controller state type.
package seq_mac_accumulator_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultAccW  = 20;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StAcc,
    StHold
  } mac_state_e;

endpackage

// File: rtl/seq_mac_accumulator_ripple_carry_adder.sv
// Ripple-carry adder built from a chain of full-adder cells.
// Ports:
//   a, b  in  W  addends
//   cin   in  1  carry into bit 0
//   sum   out W  a + b + cin, mod 2^W
//   cout  out 1  carry out of bit W-1
module seq_mac_accumulator_ripple_carry_adder #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic carry;

  // Carry is walked bit by bit through a procedural variable so the chain
  // stays a single combinational path instead of a self-referencing vector.
  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < int'(W); i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/seq_mac_accumulator.sv
// Sequential multiply-accumulate stage: one dot product per output.
// Each accepted (a, b) pair is multiplied by shift-and-add over DATA_W cycles,
// then added into a running sum; the sum is offered once the in_last pair is in.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand pair handshake (in_ready registered, high only when idle)
//   in_a, in_b, in_last   multiplicand, multiplier, final-element flag
//   out_valid/out_ready   result handshake
//   out_sum               dot-product sum mod 2^ACC_W
//   out_ovf               sticky: an accumulate add carried out of ACC_W
module seq_mac_accumulator
  import seq_mac_accumulator_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ACC_W  = DefaultAccW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int unsigned ProdW = 2 * DATA_W;
  localparam int unsigned CntW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  mac_state_e        state_q, state_d;
  logic              in_ready_q, out_valid_q, last_q, ovf_q;
  logic [DATA_W-1:0] mcand_q, mplier_q;
  logic [CntW-1:0]   cnt_q;
  logic [ProdW-1:0]  prod_q, prod_addend, prod_sum;
  logic [ACC_W-1:0]  acc_q, acc_sum, prod_ext;
  logic              acc_cout, prod_cout_unused;
  logic              accept, out_fire;

  assign accept   = in_valid & in_ready_q & (state_q == StIdle);
  assign out_fire = out_valid_q & out_ready;

  // Partial product for this step: multiplicand weighted by the current bit position.
  assign prod_addend = mplier_q[0] ? (ProdW'(mcand_q) << cnt_q) : '0;
  assign prod_ext    = ACC_W'(prod_q);

  // The product never exceeds 2*DATA_W bits, so this carry-out is always zero.
  seq_mac_accumulator_ripple_carry_adder #(
    .W (ProdW)
  ) u_prod_add (
    .a    (prod_q),
    .b    (prod_addend),
    .cin  (1'b0),
    .sum  (prod_sum),
    .cout (prod_cout_unused)
  );

  seq_mac_accumulator_ripple_carry_adder #(
    .W (ACC_W)
  ) u_acc_add (
    .a    (acc_q),
    .b    (prod_ext),
    .cin  (1'b0),
    .sum  (acc_sum),
    .cout (acc_cout)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StMul;
      StMul:   if (cnt_q == CntLast) state_d = StAcc;
      StAcc:   state_d = last_q ? StHold : StIdle;
      StHold:  if (out_fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      ovf_q       <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      // Ready only once the controller has settled in idle for a full cycle,
      // which gives the DATA_W+2 turnaround and the post-reset rise.
      in_ready_q  <= (state_q == StIdle) && (state_d == StIdle);
      out_valid_q <= (state_q == StHold) && !out_fire;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            mcand_q  <= in_a;
            mplier_q <= in_b;
            last_q   <= in_last;
            prod_q   <= '0;
            cnt_q    <= '0;
          end
        end
        StMul: begin
          prod_q   <= prod_sum;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
        end
        StAcc: begin
          acc_q <= acc_sum;
          if (acc_cout) ovf_q <= 1'b1;
        end
        StHold: begin
          if (out_fire) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_seq_mac_accumulator.sv
module tb_seq_mac_accumulator;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 20;
  localparam longint AccMod = 64'd1 << AW;

  typedef logic [7:0] ops_t[$];
  typedef struct {
    int          n;
    logic [7:0]  a[4];
    logic [7:0]  b[4];
    longint      sum;
    logic        ovf;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          in_ready, out_valid, out_ovf;
  logic [AW-1:0] out_sum;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  seq_mac_accumulator #(
    .DATA_W (DW),
    .ACC_W  (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair and hold it until the block accepts it.
  task automatic send(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic last);
    int k;
    in_a = a;
    in_b = b;
    in_last = last;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 60) begin
      tick();
      k++;
    end
    check({name, "_ready"}, longint'(in_ready), 1);
    if (in_ready) tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  // After an accept edge: count edges until in_ready (or out_valid for a last pair) rises.
  task automatic wait_after_accept(input string name, input logic last);
    int rise;
    rise = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (last ? out_valid : in_ready) begin
        rise = k;
        break;
      end
    end
    check({name, "_latency"}, rise, DW + 2);
  endtask

  task automatic collect(input string name, input longint exp_sum, input logic exp_ovf);
    check({name, "_valid"}, longint'(out_valid), 1);
    check({name, "_sum"}, longint'(out_sum), exp_sum);
    check({name, "_ovf"}, longint'(out_ovf), longint'(exp_ovf));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_drop"}, longint'(out_valid), 0);
  endtask

  task automatic run_vec(input string name, input ops_t qa, input ops_t qb,
                         input longint exp_sum, input logic exp_ovf);
    for (int i = 0; i < qa.size(); i++) begin
      send(name, qa[i], qb[i], i == qa.size() - 1);
      wait_after_accept(name, i == qa.size() - 1);
    end
    collect(name, exp_sum, exp_ovf);
  endtask

  function automatic vec_t mk(input int n, input logic [31:0] a4, input logic [31:0] b4,
                              input longint s, input logic o);
    vec_t v;
    v.n = n;
    for (int i = 0; i < 4; i++) begin
      v.a[i] = a4[8*i +: 8];
      v.b[i] = b4[8*i +: 8];
    end
    v.sum = s;
    v.ovf = o;
    return v;
  endfunction

  initial begin
    vec_t   tbl[5];
    ops_t   qa, qb;
    longint total;
    logic   seen;

    tbl[0] = mk(1, 32'h0000_0003, 32'h0000_0005, 15, 1'b0);
    tbl[1] = mk(4, 32'h0705_0301, 32'h0806_0402, 100, 1'b0);
    tbl[2] = mk(1, 32'h0000_0000, 32'h0000_00c8, 0, 1'b0);
    tbl[3] = mk(2, 32'h0000_00ff, 32'h0000_09ff, 65025, 1'b0);
    tbl[4] = mk(3, 32'h0080_01ff, 32'h0002_ff01, 766, 1'b0);

    // Reset state and registered in_ready rise.
    tick();
    tick();
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_sum", longint'(out_sum), 0);
    check("rst_out_ovf", longint'(out_ovf), 0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_before_edge", longint'(in_ready), 0);
    tick();
    check("rel_in_ready_after_edge", longint'(in_ready), 1);

    // Table-driven vectors.
    foreach (tbl[t]) begin
      qa = {};
      qb = {};
      for (int i = 0; i < tbl[t].n; i++) begin
        qa.push_back(tbl[t].a[i]);
        qb.push_back(tbl[t].b[i]);
      end
      run_vec($sformatf("tbl%0d", t), qa, qb, tbl[t].sum, tbl[t].ovf);
    end

    // Overflow: 17 x 255*255 wraps past 2^20; sticky flag then clears for the next vector.
    qa = {};
    qb = {};
    for (int i = 0; i < 17; i++) begin
      qa.push_back(8'd255);
      qb.push_back(8'd255);
    end
    run_vec("ovf17", qa, qb, 56849, 1'b1);
    qa = {8'd1};
    qb = {8'd1};
    run_vec("after_ovf", qa, qb, 1, 1'b0);

    // Back-pressure in HOLD with a pending input that must not be captured.
    send("bp", 8'd3, 8'd5, 1'b1);
    wait_after_accept("bp", 1'b1);
    in_a = 8'd9;
    in_b = 8'd9;
    in_last = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_hold%0d_sum", k), longint'(out_sum), 15);
      check($sformatf("bp_hold%0d_valid", k), longint'(out_valid), 1);
      check($sformatf("bp_hold%0d_in_ready", k), longint'(in_ready), 0);
    end
    collect("bp", 15, 1'b0);
    qa = {8'd9};
    qb = {8'd9};
    run_vec("bp_next", qa, qb, 81, 1'b0);

    // Reset in the middle of a multiply, with a partial sum already accumulated.
    send("mid", 8'd10, 8'd10, 1'b0);
    wait_after_accept("mid", 1'b0);
    send("mid2", 8'd100, 8'd100, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_in_ready", longint'(in_ready), 0);
    check("mid_rst_sum", longint'(out_sum), 0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      seen = seen | out_valid;
    end
    check("mid_no_valid", longint'(seen), 0);
    qa = {8'd2};
    qb = {8'd2};
    run_vec("mid_post", qa, qb, 4, 1'b0);

    // Randomized vectors against a plain-arithmetic dot-product model.
    for (int v = 0; v < 25; v++) begin
      int n;
      logic [7:0] a, b;
      n = int'($urandom_range(1, 20));
      qa = {};
      qb = {};
      total = 0;
      for (int i = 0; i < n; i++) begin
        a = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
        b = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
        qa.push_back(a);
        qb.push_back(b);
        total += longint'(a) * longint'(b);
      end
      run_vec($sformatf("rnd%0d", v), qa, qb, total % AccMod, total >= AccMod);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
